// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: access-size codes, load/store unit state encoding and an
// alignment helper shared by the CPU-to-RAM datapath blocks.
package cpu_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_t;

    // True when the low address bits are not a multiple of the access width.
    function automatic logic is_misaligned(input logic [2:0] addr_lsb,
                                           input logic [1:0] size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lsb[0];
            SIZE_W:  return |addr_lsb[1:0];
            default: return |addr_lsb;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// load_extender: right-justified load data is masked to the access width and
// either zero- or sign-extended to 64 bits. Purely combinational so the same
// block can sit on the cache refill path later.
module load_extender
    import cpu_mem_pkg::*;
(
    input  logic [63:0] raw64,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [63:0] ext64
);

    // Select the width and fill the upper bits with zeros or the width's MSB.
    always_comb begin
        ext64 = raw64;
        case (size)
            SIZE_B:  ext64 = {{56{is_signed & raw64[7]}},  raw64[7:0]};
            SIZE_H:  ext64 = {{48{is_signed & raw64[15]}}, raw64[15:0]};
            SIZE_W:  ext64 = {{32{is_signed & raw64[31]}}, raw64[31:0]};
            SIZE_D:  ext64 = raw64;
            default: ext64 = raw64;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store bridge between the execute stage
// and a RAM_64bit instance. IDLE -> ACCESS -> RESP -> IDLE, all outputs
// registered. Optional feature macro MISALIGN_TRAP_EN: misaligned requests
// skip the bus cycle and return resp_error = 1 one cycle after acceptance.
// Requires ADDR_WIDTH >= 3.
module load_store_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_signed,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [63:0]           mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [1:0]            mem_size
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic        accept;
    logic        go_access;
    logic        misaligned;
    logic        req_write_q;
    logic        req_signed_q;
    logic [1:0]  req_size_q;
    logic [63:0] req_wdata_q;
    logic [63:0] ext_data;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(req_addr[2:0], req_size);
`else
    assign misaligned = 1'b0;
`endif

    // Misaligned requests (trap build only) go straight to RESP with no bus cycle.
    assign go_access = accept && !misaligned;

    // The unit only drives the shared data bus during a store's ACCESS cycle.
    assign mem_data = (mem_cs && mem_we) ? req_wdata_q : 64'bz;

    load_extender u_extender (
        .raw64     (mem_data),
        .size      (req_size_q),
        .is_signed (req_signed_q),
        .ext64     (ext_data)
    );

    // Next-state logic; a request is taken only while req_ready is advertised.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = misaligned ? LSU_RESP : LSU_ACCESS;
                end
            end
            LSU_ACCESS: state_next = LSU_RESP;
            LSU_RESP: begin
                if (resp_ready) begin
                    state_next = LSU_IDLE;
                end
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    // State register; reset drops any request in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request attributes the later cycles still need.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_write_q  <= 1'b0;
            req_signed_q <= 1'b0;
            req_size_q   <= SIZE_B;
            req_wdata_q  <= '0;
        end else if (accept) begin
            req_write_q  <= req_write;
            req_signed_q <= req_signed;
            req_size_q   <= req_size;
            req_wdata_q  <= req_wdata;
        end
    end

    // RAM control strobes are high for exactly the ACCESS cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            mem_address <= '0;
            mem_size    <= SIZE_B;
        end else begin
            mem_cs <= go_access;
            mem_we <= go_access && req_write;
            mem_oe <= go_access && !req_write;
            if (go_access) begin
                mem_address <= req_addr;
                mem_size    <= req_size;
            end
        end
    end

    // Handshake flags follow the next state; load data is captured as ACCESS ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            req_ready  <= (state_next == LSU_IDLE);
            resp_valid <= (state_next == LSU_RESP);
            if (state == LSU_ACCESS) begin
                resp_rdata <= req_write_q ? 64'd0 : ext_data;
            end else if (accept && misaligned) begin
                resp_rdata <= 64'd0;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Error flag is set for a trapped request and cleared once its response is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_error <= 1'b0;
        end else if (accept) begin
            resp_error <= misaligned;
        end else if (state == LSU_RESP && resp_ready) begin
            resp_error <= 1'b0;
        end
    end
`else
    assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: load_store_unit against a behavioural little-endian
// RAM_64bit model, with an expected-response queue.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_signed;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [11:0] mem_address;
    wire  [63:0] mem_data;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
    logic [1:0]  mem_size;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        w;
        logic        sg;
        logic [1:0]  sz;
        logic [11:0] a;
        logic [63:0] wd;
        logic [63:0] nominal;
    } vec_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cs_cycles = 0;
    logic [7:0]  ram [4096];
    logic [63:0] ram_rd;

    always #5 clock = ~clock;

    load_store_unit #(.ADDR_WIDTH(12)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_signed  (req_signed),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe),
        .mem_size    (mem_size)
    );

    // RAM model: little-endian byte writes, address wraps at 4 KiB.
    always @(posedge clock) begin
        if (mem_cs && mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (1 << mem_size)) begin
                    ram[mem_address + 12'(i)] <= mem_data[8*i +: 8];
                end
            end
        end
    end

    // RAM model: right-justified read data, upper bytes zero.
    always_comb begin
        ram_rd = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << mem_size)) begin
                ram_rd[8*i +: 8] = ram[mem_address + 12'(i)];
            end
        end
    end

    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_rd : 64'bz;

    // Count cycles in which the RAM is selected.
    always @(negedge clock) begin
        if (mem_cs) begin
            cs_cycles <= cs_cycles + 1;
        end
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk_vec(input logic w, input logic sg, input logic [1:0] sz,
                                    input logic [11:0] a, input logic [63:0] wd,
                                    input logic [63:0] nominal);
        vec_t v;
        v.w = w; v.sg = sg; v.sz = sz; v.a = a; v.wd = wd; v.nominal = nominal;
        return v;
    endfunction

    // Expected response; a trapping build turns misaligned requests into 1-cycle errors.
    function automatic exp_t make_exp(input logic [1:0] sz, input logic [11:0] a,
                                      input logic [63:0] nominal);
        exp_t e;
        e.rdata = nominal;
        e.err   = 1'b0;
        e.lat   = 2;
`ifdef MISALIGN_TRAP_EN
        if ((a & ((12'd1 << sz) - 12'd1)) != 12'd0) begin
            e.rdata = 64'd0;
            e.err   = 1'b1;
            e.lat   = 1;
        end
`endif
        return e;
    endfunction

    // Present a request at a falling edge once ready; returns one negedge after acceptance.
    task automatic send_req(input logic w, input logic sg, input logic [1:0] sz,
                            input logic [11:0] a, input logic [63:0] wd);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        req_write  = w;
        req_signed = sg;
        req_size   = sz;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(negedge clock);
        req_valid  = 1'b0;
    endtask

    // Latency counts falling edges after the accepting edge; -1 means timeout.
    task automatic wait_resp(output logic [63:0] rd, output logic er, output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!resp_valid) lat = -1;
        rd = resp_rdata;
        er = resp_error;
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_signed = 1'b0;
        req_size   = 2'b00;
        req_addr   = 12'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({req_ready, resp_valid, resp_error, mem_cs, mem_we, mem_oe, mem_size, mem_address, resp_rdata} !== 84'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {req_ready, resp_valid, resp_error, mem_cs, mem_we, mem_oe, mem_size, mem_address, resp_rdata});
        end
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        vec_t        tbl[$];
        vec_t        v;
        exp_t        e;
        logic [63:0] rd;
        logic        er;
        int          lat;
        tbl.push_back(mk_vec(1'b1, 1'b0, 2'b11, 12'd8,  64'h0706050403020100, 64'd0));
        tbl.push_back(mk_vec(1'b0, 1'b0, 2'b11, 12'd8,  64'd0, 64'h0706050403020100));
        tbl.push_back(mk_vec(1'b1, 1'b0, 2'b00, 12'd16, 64'h80, 64'd0));
        tbl.push_back(mk_vec(1'b0, 1'b1, 2'b00, 12'd16, 64'd0, 64'hFFFFFFFFFFFFFF80));
        tbl.push_back(mk_vec(1'b0, 1'b0, 2'b00, 12'd16, 64'd0, 64'h0000000000000080));
        tbl.push_back(mk_vec(1'b1, 1'b0, 2'b10, 12'd17, 64'h8C0B0A09, 64'd0));
        tbl.push_back(mk_vec(1'b0, 1'b1, 2'b10, 12'd17, 64'd0, 64'hFFFFFFFF8C0B0A09));
        tbl.push_back(mk_vec(1'b0, 1'b1, 2'b01, 12'd19, 64'd0, 64'hFFFFFFFFFFFF8C0B));
        tbl.push_back(mk_vec(1'b0, 1'b0, 2'b01, 12'd19, 64'd0, 64'h0000000000008C0B));
        tbl.push_back(mk_vec(1'b0, 1'b1, 2'b11, 12'd8,  64'd0, 64'h0706050403020100));
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            e = make_exp(v.sz, v.a, v.nominal);
            exp_q.push_back(e);
            send_req(v.w, v.sg, v.sz, v.a, v.wd);
            vectors++;
            if (e.err ? ({mem_cs, mem_we, mem_oe} !== 3'b000)
                      : ({mem_cs, mem_we, mem_oe, mem_address, mem_size} !== {1'b1, v.w, !v.w, v.a, v.sz})) begin
                miscompares++;
                $display("[TB] FAIL store_load[%0d] bus: got cs/we/oe=%b%b%b addr=%h size=%b, expected addr=%h size=%b",
                         i, mem_cs, mem_we, mem_oe, mem_address, mem_size, v.a, v.sz);
            end
            wait_resp(rd, er, lat);
            ack_resp();
            e = exp_q.pop_front();
            vectors++;
            if (rd !== e.rdata) begin
                miscompares++;
                $display("[TB] FAIL store_load[%0d] rdata: got %h, expected %h", i, rd, e.rdata);
            end
            vectors++;
            if (er !== e.err) begin
                miscompares++;
                $display("[TB] FAIL store_load[%0d] error: got %b, expected %b", i, er, e.err);
            end
            vectors++;
            if (lat != e.lat) begin
                miscompares++;
                $display("[TB] FAIL store_load[%0d] latency: got %0d, expected %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_hold();
        exp_t        e;
        logic [63:0] rd;
        logic        er;
        int          lat;
        exp_q.push_back(make_exp(2'b00, 12'd16, 64'hFFFFFFFFFFFFFF80));
        send_req(1'b0, 1'b1, 2'b00, 12'd16, 64'd0);
        wait_resp(rd, er, lat);
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e.rdata || lat != e.lat) begin
            miscompares++;
            $display("[TB] FAIL hold_first: got rdata=%h lat=%0d, expected rdata=%h lat=%0d", rd, lat, e.rdata, e.lat);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            vectors++;
            if ({resp_valid, req_ready, mem_cs, mem_we, resp_rdata} !== {4'b1000, e.rdata}) begin
                miscompares++;
                $display("[TB] FAIL hold_cycle[%0d]: got valid=%b ready=%b cs=%b we=%b rdata=%h, expected 1000 rdata=%h",
                         c, resp_valid, req_ready, mem_cs, mem_we, resp_rdata, e.rdata);
            end
        end
        ack_resp();
        vectors++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL hold_release: got valid/ready=%b%b, expected 01", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_access();
        exp_t        e;
        logic [63:0] rd;
        logic        er;
        int          lat;
        send_req(1'b0, 1'b0, 2'b11, 12'd8, 64'd0);
        vectors++;
        if (mem_cs !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_in_access: got cs=%b, expected 1", mem_cs);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, resp_valid, resp_error, mem_cs, mem_we, mem_oe, mem_size, mem_address, resp_rdata} !== 84'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_outputs: got %h, expected 0",
                     {req_ready, resp_valid, resp_error, mem_cs, mem_we, mem_oe, mem_size, mem_address, resp_rdata});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            vectors++;
            if (resp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_no_resp[%0d]: got valid=%b, expected 0", c, resp_valid);
            end
        end
        exp_q.push_back(make_exp(2'b11, 12'd8, 64'h0706050403020100));
        send_req(1'b0, 1'b0, 2'b11, 12'd8, 64'd0);
        wait_resp(rd, er, lat);
        ack_resp();
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e.rdata || lat != e.lat) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_recovery: got rdata=%h lat=%0d, expected rdata=%h lat=%0d", rd, lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_misalign();
        exp_t        e;
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          cs0;
        exp_q.push_back(make_exp(2'b10, 12'd13, 64'hFFFFFFFF80070605));
        cs0 = cs_cycles;
        send_req(1'b0, 1'b1, 2'b10, 12'd13, 64'd0);
        wait_resp(rd, er, lat);
        ack_resp();
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e.rdata) begin
            miscompares++;
            $display("[TB] FAIL misalign_rdata: got %h, expected %h", rd, e.rdata);
        end
        vectors++;
        if (er !== e.err || lat != e.lat) begin
            miscompares++;
            $display("[TB] FAIL misalign_error: got err=%b lat=%0d, expected err=%b lat=%0d", er, lat, e.err, e.lat);
        end
        vectors++;
        if ((cs_cycles - cs0) != (e.err ? 0 : 1)) begin
            miscompares++;
            $display("[TB] FAIL misalign_cs_cycles: got %0d, expected %0d", cs_cycles - cs0, e.err ? 0 : 1);
        end
    endtask

    task automatic test_wrap();
        vec_t        tbl[$];
        vec_t        v;
        exp_t        e;
        logic [63:0] rd;
        logic        er;
        int          lat;
        tbl.push_back(mk_vec(1'b1, 1'b0, 2'b01, 12'hFFF, 64'hBEEF, 64'd0));
        tbl.push_back(mk_vec(1'b0, 1'b0, 2'b01, 12'hFFF, 64'd0, 64'h000000000000BEEF));
        tbl.push_back(mk_vec(1'b0, 1'b1, 2'b01, 12'hFFF, 64'd0, 64'hFFFFFFFFFFFFBEEF));
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            exp_q.push_back(make_exp(v.sz, v.a, v.nominal));
            send_req(v.w, v.sg, v.sz, v.a, v.wd);
            wait_resp(rd, er, lat);
            ack_resp();
            e = exp_q.pop_front();
            vectors++;
            if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
                miscompares++;
                $display("[TB] FAIL wrap[%0d]: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   seen = 0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(make_exp(2'b01, 12'd10, 64'h0000000000000302));
        end
        req_write  = 1'b0;
        req_signed = 1'b1;
        req_size   = 2'b01;
        req_addr   = 12'd10;
        req_wdata  = 64'd0;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (c == 9) req_valid = 1'b0;
            if (resp_valid) begin
                seen++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_extra_resp: got response at cycle %0d, expected none", c);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_rdata !== e.rdata || (c % 3) != 2) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_resp: got rdata=%h at cycle %0d, expected rdata=%h at cycle 2/5/8",
                                 resp_rdata, c, e.rdata);
                    end
                end
            end
        end
        resp_ready = 1'b0;
        vectors++;
        if (seen != 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d responses, expected 3", seen);
        end
        exp_q.delete();
        @(negedge clock);
    endtask

    initial begin
        $display("[TB] load_store_unit bench start");
        test_reset();
        test_store_load();
        test_hold();
        test_reset_mid_access();
        test_misalign();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
